// File: rtl/div_radix2_pkg.sv
// div_radix2_pkg: shared width and state encoding for the radix-2 divider
//   DIV_WIDTH    default operand width
//   div_state_e  divider FSM states
//   DIV_RES_HI / DIV_RES_LO  index of remainder / quotient halves in the result pair
package div_radix2_pkg;

    localparam int DIV_WIDTH  = 32;
    localparam int DIV_RES_HI = 1;
    localparam int DIV_RES_LO = 0;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_DIVZERO = 2'd1,
        DIV_CALC    = 2'd2,
        DIV_DONE    = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_radix2.sv
// div_radix2: multi-cycle restoring radix-2 integer divider for HI/LO writes
//   clk        clock, rising edge
//   resetn     synchronous reset, active low
//   start      division request, accepted only in IDLE
//   signed_div 1 = signed DIV, 0 = DIVU; sampled with start
//   opdata1    dividend; sampled with start
//   opdata2    divisor; sampled with start
//   annul      abort any in-flight division
//   busy       pipeline stall request (combinational)
//   ready      one-cycle result-valid pulse
//   result     {remainder, quotient}, held until the next completion
module div_radix2
    import div_radix2_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               signed_div,
    input  logic [WIDTH-1:0]   opdata1,
    input  logic [WIDTH-1:0]   opdata2,
    input  logic               annul,
    output logic               busy,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] v);
        return ~v + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? neg(v) : v;
    endfunction

    div_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             sdiv_q, sdiv_d;
    logic [2*WIDTH-1:0] result_q, result_d;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] rem_sub, rem_nx, quo_sh, q_fix, r_fix;
    logic             take;

    // One restoring step: the shifted partial remainder needs WIDTH+1 bits,
    // while the post-subtract remainder is always below the divisor.
    always_comb begin
        rem_sh  = {rem_q, quo_q[WIDTH-1]};
        take    = rem_sh >= {1'b0, div_q};
        rem_sub = rem_sh[WIDTH-1:0] - div_q;
        rem_nx  = take ? rem_sub : rem_sh[WIDTH-1:0];
        quo_sh  = {quo_q[WIDTH-2:0], take};
        q_fix   = (sdiv_q & (s1_q ^ s2_q)) ? neg(quo_sh) : quo_sh;
        r_fix   = (sdiv_q & s1_q) ? neg(rem_nx) : rem_nx;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        div_d    = div_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        sdiv_d   = sdiv_q;
        result_d = result_q;
        busy     = 1'b0;
        ready    = 1'b0;
        case (state_q)
            DIV_IDLE: begin
                if (start && !annul) begin
                    busy    = 1'b1;
                    s1_d    = signed_div & opdata1[WIDTH-1];
                    s2_d    = signed_div & opdata2[WIDTH-1];
                    sdiv_d  = signed_div;
                    cnt_d   = '0;
                    rem_d   = '0;
                    div_d   = signed_div ? abs_val(opdata2) : opdata2;
                    // Divide-by-zero reports the raw dividend, so keep it unmodified.
                    quo_d   = (signed_div && opdata2 != '0) ? abs_val(opdata1) : opdata1;
                    state_d = (opdata2 == '0) ? DIV_DIVZERO : DIV_CALC;
                end
            end
            DIV_DIVZERO: begin
                busy     = 1'b1;
                state_d  = annul ? DIV_IDLE : DIV_DONE;
                result_d = annul ? result_q : {quo_q, {WIDTH{1'b1}}};
            end
            DIV_CALC: begin
                busy = 1'b1;
                if (annul) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_sh;
                    if (cnt_q == CW'(WIDTH-1)) begin
                        result_d = {r_fix, q_fix};
                        state_d  = DIV_DONE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            default: begin
                ready   = ~annul;
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            div_q    <= '0;
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            sdiv_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            div_q    <= div_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            sdiv_q   <= sdiv_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_div_radix2.sv
// tb_div_radix2: directed self-checking bench for div_radix2
module tb_div_radix2;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        annul = 1'b0;
    logic        busy;
    logic        ready;
    logic [63:0] result;

    int n_checks = 0;
    int n_fail = 0;

    div_radix2 dut (
        .clk(clk), .resetn(resetn), .start(start), .signed_div(signed_div),
        .opdata1(opdata1), .opdata2(opdata2), .annul(annul),
        .busy(busy), .ready(ready), .result(result)
    );

    always #5 clk = ~clk;

    // Issues one request and watches until ready (bounded); no comparisons here.
    // lat = cycles from accept to ready (-1 on timeout), nbusy = busy-high cycles before ready.
    task automatic run(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                       output int lat, output int nbusy, output logic [63:0] res);
        @(negedge clk);
        start = 1'b1; signed_div = sgn; opdata1 = a; opdata2 = b;
        #1;
        nbusy = int'(busy);
        lat = -1;
        res = '0;
        @(negedge clk);
        start = 1'b0; opdata1 = $urandom; opdata2 = $urandom; signed_div = ~sgn;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (ready) begin
                lat = k;
                res = result;
                break;
            end
            nbusy += int'(busy);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
            n_fail++;
            $display("FAIL reset: busy=%b ready=%b result=%h, want 0 0 0", busy, ready, result);
        end
        resetn = 1'b1;
    endtask

    task automatic test_unsigned();
        int lat, nb;
        logic [63:0] r;
        run(32'd100, 32'd7, 1'b0, lat, nb, r);
        n_checks++;
        if (lat !== 33) begin n_fail++; $display("FAIL u100_7 latency: got %0d want 33", lat); end
        n_checks++;
        if (nb !== 33) begin n_fail++; $display("FAIL u100_7 busy cycles: got %0d want 33", nb); end
        n_checks++;
        if (r !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL u100_7 result: got %h want %h", r, {32'd2, 32'd14}); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL u100_7 busy in done: got %b want 0", busy); end
        @(negedge clk); #1;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL u100_7 ready pulse width: got %b want 0", ready); end
        n_checks++;
        if (result !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL u100_7 result hold: got %h", result); end
    endtask

    task automatic test_signed();
        int lat, nb;
        logic [63:0] r;
        run(32'hFFFFFFF9, 32'd2, 1'b1, lat, nb, r);
        n_checks++;
        if (r !== {32'hFFFFFFFF, 32'hFFFFFFFD} || lat !== 33) begin
            n_fail++; $display("FAIL s-7_2: got %h lat %0d want ffffffff_fffffffd lat 33", r, lat);
        end
        run(32'd7, 32'hFFFFFFFE, 1'b1, lat, nb, r);
        n_checks++;
        if (r !== {32'd1, 32'hFFFFFFFD} || lat !== 33) begin
            n_fail++; $display("FAIL s7_-2: got %h lat %0d want 00000001_fffffffd lat 33", r, lat);
        end
        run(32'hFFFFFFEC, 32'hFFFFFFFA, 1'b1, lat, nb, r);
        n_checks++;
        if (r !== {32'hFFFFFFFE, 32'd3}) begin
            n_fail++; $display("FAIL s-20_-6: got %h want fffffffe_00000003", r);
        end
    endtask

    task automatic test_overflow();
        int lat, nb;
        logic [63:0] r;
        run(32'h80000000, 32'hFFFFFFFF, 1'b1, lat, nb, r);
        n_checks++;
        if (r !== {32'd0, 32'h80000000}) begin
            n_fail++; $display("FAIL s_min_-1: got %h want 00000000_80000000", r);
        end
        run(32'h80000000, 32'hFFFFFFFF, 1'b0, lat, nb, r);
        n_checks++;
        if (r !== {32'h80000000, 32'd0}) begin
            n_fail++; $display("FAIL u_min_max: got %h want 80000000_00000000", r);
        end
        run(32'hFFFFFFFF, 32'd1, 1'b0, lat, nb, r);
        n_checks++;
        if (r !== {32'd0, 32'hFFFFFFFF}) begin
            n_fail++; $display("FAIL u_max_1: got %h want 00000000_ffffffff", r);
        end
    endtask

    task automatic test_divzero();
        int lat, nb;
        logic [63:0] r;
        run(32'd5, 32'd0, 1'b0, lat, nb, r);
        n_checks++;
        if (lat !== 2 || nb !== 2) begin n_fail++; $display("FAIL u5_0 timing: lat %0d busy %0d want 2 2", lat, nb); end
        n_checks++;
        if (r !== {32'd5, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL u5_0 result: got %h want 00000005_ffffffff", r); end
        run(32'd5, 32'd0, 1'b1, lat, nb, r);
        n_checks++;
        if (lat !== 2 || r !== {32'd5, 32'hFFFFFFFF}) begin
            n_fail++; $display("FAIL s5_0: got %h lat %0d want 00000005_ffffffff lat 2", r, lat);
        end
        run(32'hFFFFFFF9, 32'd0, 1'b1, lat, nb, r);
        n_checks++;
        if (r !== {32'hFFFFFFF9, 32'hFFFFFFFF}) begin
            n_fail++; $display("FAIL s-7_0 raw dividend: got %h want fffffff9_ffffffff", r);
        end
    endtask

    task automatic test_annul();
        logic [63:0] prev;
        int pulses;
        int lat, nb;
        logic [63:0] r;
        prev = result;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd1000; opdata2 = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL annul busy at T+10: got %b want 1", busy); end
        @(negedge clk);
        annul = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL annul busy at T+11: got %b want 0", busy); end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk); #1;
            pulses += int'(ready) + int'(busy);
        end
        n_checks++;
        if (pulses !== 0) begin n_fail++; $display("FAIL annul quiet: got %0d ready/busy cycles want 0", pulses); end
        n_checks++;
        if (result !== prev) begin n_fail++; $display("FAIL annul result: got %h want %h", result, prev); end
        @(negedge clk);
        start = 1'b1; annul = 1'b1; opdata1 = 32'd9; opdata2 = 32'd2;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL annul+start busy: got %b want 0", busy); end
        @(negedge clk);
        start = 1'b0; annul = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0) begin n_fail++; $display("FAIL annul+start accepted: busy %b ready %b", busy, ready); end
        run(32'd1000, 32'd3, 1'b0, lat, nb, r);
        n_checks++;
        if (lat !== 33 || r !== {32'd1, 32'd333}) begin
            n_fail++; $display("FAIL after annul: got %h lat %0d want 00000001_0000014d lat 33", r, lat);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd50; opdata2 = 32'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || ready !== 1'b0 || result !== 64'd0) begin
            n_fail++; $display("FAIL reset mid-calc: busy %b ready %b result %h want 0 0 0", busy, ready, result);
        end
        resetn = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        n_checks++;
        if (result !== 64'd0) begin n_fail++; $display("FAIL reset abandon: result %h want 0", result); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7;
        lat = -1;
        for (int k = 0; k <= 40; k++) begin
            #1;
            if (ready) begin lat = k; break; end
            @(negedge clk);
        end
        n_checks++;
        if (lat !== 33 || busy !== 1'b0) begin n_fail++; $display("FAIL held start first: lat %0d busy %b want 33 0", lat, busy); end
        @(negedge clk); #1;
        n_checks++;
        if (busy !== 1'b1 || ready !== 1'b0) begin n_fail++; $display("FAIL held start reaccept: busy %b ready %b want 1 0", busy, ready); end
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            #1;
            if (ready) begin lat = k; break; end
            @(negedge clk);
        end
        n_checks++;
        if (lat !== 33 || result !== {32'd2, 32'd14}) begin
            n_fail++; $display("FAIL held start second: lat %0d result %h want 33 00000002_0000000e", lat, result);
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_overflow();
        test_divzero();
        test_annul();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
